// File: rtl/decoder_mcycle_sequencer.sv
// decoder_mcycle_sequencer: T-state counter and bus-control flag decode for M1/MEM-RD/MEM-WR/IO machine cycles
// Ports: CLK, notRESET (async active-low); START/MTYPE/IOWR request a cycle, TWAIT holds the sample state;
// XPT/notXPT T-state index, BUSY, DONE, Flag_* bus controls, SelectAd_* address selects,
// Latch_Data/Halt_XPT sample strobes, Inc_R and R refresh register, WAIT_ERR sticky timeout.
// Optional wait timeout: define DECODER_WAIT_TIMEOUT_EN.
module decoder_mcycle_sequencer #(
    parameter int R_W      = 7,
    parameter int WAIT_MAX = 15
) (
    input  logic           CLK,
    input  logic           notRESET,
    input  logic           START,
    input  logic [1:0]     MTYPE,
    input  logic           IOWR,
    input  logic           TWAIT,
    output logic [1:0]     XPT,
    output logic [1:0]     notXPT,
    output logic           BUSY,
    output logic           DONE,
    output logic           Flag_M1,
    output logic           Flag_MREQ,
    output logic           Flag_IORQ,
    output logic           Flag_RD,
    output logic           Flag_WR,
    output logic           Flag_RFSH,
    output logic           SelectAd_PC,
    output logic           SelectAd_IR,
    output logic           Latch_Data,
    output logic           Halt_XPT,
    output logic           Inc_R,
    output logic [R_W-1:0] R,
    output logic           WAIT_ERR
);
    typedef enum logic [1:0] {MT_M1, MT_RD, MT_WR, MT_IO} mtype_e;
    mtype_e         mtype_q, mtype_d;
    logic           busy_q, busy_d, iowr_q, iowr_d;
    logic [1:0]     xpt_q, xpt_d;
    logic [R_W-1:0] r_q, r_d;
    logic           m1, rd, wr, io, sample, force_adv, accept;
`ifdef DECODER_WAIT_TIMEOUT_EN
    localparam int WC_W = $clog2(WAIT_MAX + 1);
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic            werr_q, werr_d;
    assign force_adv = sample && !TWAIT && wcnt_q == WC_W'(WAIT_MAX);
    assign WAIT_ERR  = werr_q;
    always_comb begin
        wcnt_d = Halt_XPT ? wcnt_q + WC_W'(1) : '0;
        werr_d = accept ? 1'b0 : (werr_q || force_adv);
    end
    always_ff @(posedge CLK or negedge notRESET)
        if (!notRESET) begin
            wcnt_q <= '0;
            werr_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            werr_q <= werr_d;
        end
`else
    assign force_adv = 1'b0;
    assign WAIT_ERR  = 1'b0;
`endif
    always_comb begin
        m1          = busy_q && mtype_q == MT_M1;
        rd          = busy_q && mtype_q == MT_RD;
        wr          = busy_q && mtype_q == MT_WR;
        io          = busy_q && mtype_q == MT_IO;
        XPT         = xpt_q;
        notXPT      = ~xpt_q;
        BUSY        = busy_q;
        DONE        = busy_q && xpt_q == ((m1 || io) ? 2'd3 : 2'd2);
        sample      = busy_q && xpt_q == (io ? 2'd2 : 2'd1);
        Flag_M1     = m1 && !xpt_q[1];
        Flag_MREQ   = m1 || wr || (rd && !xpt_q[1]);
        Flag_IORQ   = io && (xpt_q[1] ^ xpt_q[0]);
        Flag_RD     = ((m1 || rd) && !xpt_q[1]) || (Flag_IORQ && !iowr_q);
        Flag_WR     = (wr && xpt_q == 2'd1) || (Flag_IORQ && iowr_q);
        Flag_RFSH   = m1 && xpt_q[1];
        SelectAd_PC = Flag_M1;
        SelectAd_IR = Flag_RFSH;
        Inc_R       = m1 && xpt_q == 2'd3;
        Latch_Data  = sample && TWAIT;
        Halt_XPT    = sample && !TWAIT && !force_adv;
        R           = r_q;
        accept      = START && (!busy_q || DONE);
        busy_d      = accept || (busy_q && !DONE);
        xpt_d       = (accept || DONE) ? 2'd0 : (busy_q && !Halt_XPT) ? xpt_q + 2'd1 : xpt_q;
        mtype_d     = accept ? mtype_e'(MTYPE) : mtype_q;
        iowr_d      = accept ? IOWR : iowr_q;
        r_d         = Inc_R ? {r_q[R_W-1], r_q[R_W-2:0] + (R_W-1)'(1)} : r_q;
    end
    always_ff @(posedge CLK or negedge notRESET)
        if (!notRESET) begin
            busy_q  <= 1'b0;
            xpt_q   <= 2'd0;
            mtype_q <= MT_M1;
            iowr_q  <= 1'b0;
            r_q     <= '0;
        end else begin
            busy_q  <= busy_d;
            xpt_q   <= xpt_d;
            mtype_q <= mtype_d;
            iowr_q  <= iowr_d;
            r_q     <= r_d;
        end
endmodule

// File: tb/tb_decoder_mcycle_sequencer.sv
// tb_decoder_mcycle_sequencer: randomized and directed bench against a table-driven machine-cycle model
module tb_decoder_mcycle_sequencer;
`ifdef DECODER_WAIT_TIMEOUT_EN
    localparam int WMAX  = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int WMAX  = 15;
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [9:0] F_M1 = 10'h200, F_MREQ = 10'h100, F_IORQ = 10'h080, F_RD = 10'h040,
                           F_WR = 10'h020, F_RFSH = 10'h010, F_PC = 10'h008, F_IR = 10'h004,
                           F_INC = 10'h002, F_DONE = 10'h001;
    logic       CLK = 1'b0, notRESET = 1'b0, START = 1'b0, IOWR = 1'b0, TWAIT = 1'b1;
    logic [1:0] MTYPE = 2'd0;
    logic [1:0] XPT, notXPT;
    logic       BUSY, DONE, Flag_M1, Flag_MREQ, Flag_IORQ, Flag_RD, Flag_WR, Flag_RFSH;
    logic       SelectAd_PC, SelectAd_IR, Latch_Data, Halt_XPT, Inc_R, WAIT_ERR;
    logic [6:0] R;
    int         n_checks = 0, n_fail = 0;
    int         m_busy, m_type, m_t, m_iowr, m_wc, m_werr;
    logic [6:0] m_r;

    decoder_mcycle_sequencer #(.R_W(7), .WAIT_MAX(WMAX)) dut (
        .CLK(CLK), .notRESET(notRESET), .START(START), .MTYPE(MTYPE), .IOWR(IOWR), .TWAIT(TWAIT),
        .XPT(XPT), .notXPT(notXPT), .BUSY(BUSY), .DONE(DONE), .Flag_M1(Flag_M1),
        .Flag_MREQ(Flag_MREQ), .Flag_IORQ(Flag_IORQ), .Flag_RD(Flag_RD), .Flag_WR(Flag_WR),
        .Flag_RFSH(Flag_RFSH), .SelectAd_PC(SelectAd_PC), .SelectAd_IR(SelectAd_IR),
        .Latch_Data(Latch_Data), .Halt_XPT(Halt_XPT), .Inc_R(Inc_R), .R(R), .WAIT_ERR(WAIT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int cyc_len(input int typ);
        return (typ == 0 || typ == 3) ? 4 : 3;
    endfunction

    function automatic int samp_t(input int typ);
        return typ == 3 ? 2 : 1;
    endfunction

    function automatic logic [9:0] flag_tbl(input int typ, input int t, input int iw);
        case (typ)
            0: return t < 2 ? (F_M1 | F_MREQ | F_RD | F_PC)
                            : (F_RFSH | F_MREQ | F_IR | (t == 3 ? (F_INC | F_DONE) : 10'h0));
            1: return t < 2 ? (F_MREQ | F_RD) : F_DONE;
            2: return t == 0 ? F_MREQ : t == 1 ? (F_MREQ | F_WR) : (F_MREQ | F_DONE);
            default: return t == 0 ? 10'h0 : t == 3 ? F_DONE : (F_IORQ | (iw != 0 ? F_WR : F_RD));
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_type = 0; m_t = 0; m_iowr = 0; m_wc = 0; m_werr = 0; m_r = 7'h00;
    endtask

    task automatic check_outs();
        bit         insamp, frc;
        logic [1:0] tt;
        insamp = m_busy != 0 && m_t == samp_t(m_type);
        frc    = TO_EN && insamp && !TWAIT && m_wc == WMAX;
        tt     = 2'(m_t);
        chk("flags", {20'h0, Latch_Data, Halt_XPT, Flag_M1, Flag_MREQ, Flag_IORQ, Flag_RD, Flag_WR,
                      Flag_RFSH, SelectAd_PC, SelectAd_IR, Inc_R, DONE},
            {20'h0, insamp && TWAIT, insamp && !TWAIT && !frc,
             m_busy != 0 ? flag_tbl(m_type, m_t, m_iowr) : 10'h0});
        chk("state", {26'h0, BUSY, XPT, notXPT, WAIT_ERR},
            {26'h0, m_busy != 0, tt, ~tt, m_werr != 0});
        chk("r", {25'h0, R}, {25'h0, m_r});
    endtask

    task automatic model_step();
        bit done, insamp, frc;
        done   = m_busy != 0 && m_t == cyc_len(m_type) - 1;
        insamp = m_busy != 0 && m_t == samp_t(m_type);
        frc    = TO_EN && insamp && !TWAIT && m_wc == WMAX;
        if (done && m_type == 0) m_r = (m_r & 7'h40) | ((m_r + 7'd1) & 7'h3F);
        if (START && (m_busy == 0 || done)) begin
            m_busy = 1; m_t = 0; m_type = int'(MTYPE); m_iowr = int'(IOWR); m_wc = 0; m_werr = 0;
        end else if (done) begin
            m_busy = 0; m_t = 0;
        end else if (m_busy != 0) begin
            if (!insamp || TWAIT) begin
                m_t++; m_wc = 0;
            end else if (frc) begin
                m_t++; m_wc = 0; m_werr = 1;
            end else m_wc++;
        end
    endtask

    task automatic cycle(input bit st, input int mt, input bit iw, input bit tw);
        START = st; MTYPE = 2'(mt); IOWR = iw; TWAIT = tw;
        #1 check_outs();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    initial begin
        model_reset();
        #3 check_outs();
        @(negedge CLK);
        notRESET = 1'b1;
        cycle(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
        cycle(1, 1, 0, 1);
        cycle(0, 1, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1);
        cycle(1, 3, 1, 1);
        cycle(0, 3, 1, 1);
        cycle(0, 3, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 3, 1, 1);
        cycle(1, 2, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 2, 0, 1);
        for (int i = 0; i < 66 * 4; i++) cycle(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
        cycle(1, 1, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1);
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        START = 1'b0;
        #2 notRESET = 1'b0;
        model_reset();
        #1 check_outs();
        @(negedge CLK);
        notRESET = 1'b1;
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 2) != 0, int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
